sel_pipe_mux: RTL and testbench

- Parametrised N-to-1 channel selector with one registered output stage and valid/ready handshakes on every channel.
- Replaces plain combinational 2:1 selectors on datapath points that need flow control, such as the writeback and bus-return paths of the multicycle CPU.
- Selection is either driven externally or made by an internal round-robin arbiter, chosen by a parameter.

---
 rtl/sel_pipe_mux.sv | 132 +++++++++++++
 tb/tb_sel_pipe_mux.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_pipe_mux.sv
// N-to-1 channel selector with one registered output stage and valid/ready on every channel.
// Optional handshake counter port xfer_cnt when SEL_PIPE_MUX_CNT_EN is defined.
module sel_pipe_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      select,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef SEL_PIPE_MUX_CNT_EN
    ,
    output logic [31:0]          xfer_cnt
`endif
);

    logic                 load_en_s;
    logic                 has_grant_s;
    logic                 grant_valid_s;
    logic                 xfer_s;
    logic [SELW-1:0]      grant_s;
    logic [SELW-1:0]      rr_next_s;
    logic [SELW-1:0]      rr_ptr_r;
    logic [2*NCH-1:0]     rot_wide_s;
    int                   rr_sum_s;
    logic [WIDTH-1:0]     grant_data_s;
    logic [WIDTH-1:0]     out_data_r;
    logic [SELW-1:0]      out_chan_r;
    logic                 out_valid_r;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign load_en_s = !out_valid_r || out_ready;
    assign xfer_s    = has_grant_s && grant_valid_s && load_en_s;
    assign rr_next_s = (int'(grant_s) == NCH - 1) ? {SELW{1'b0}} : grant_s + {{(SELW-1){1'b0}}, 1'b1};

    // Grant selection: external select with range check, or round-robin search from rr_ptr.
    always_comb begin
        grant_s     = {SELW{1'b0}};
        has_grant_s = 1'b0;
        rot_wide_s  = {in_valid, in_valid} >> rr_ptr_r;
        rr_sum_s    = 0;
        if (MODE == 0) begin
            if (32'(select) < 32'(NCH)) begin
                grant_s     = select;
                has_grant_s = 1'b1;
            end else begin
                grant_s     = {SELW{1'b0}};
                has_grant_s = 1'b0;
            end
        end else begin
            // Scan downwards so the smallest offset from rr_ptr is the one that sticks.
            for (int j = NCH - 1; j >= 0; j--) begin
                rr_sum_s = int'(rr_ptr_r) + j;
                rr_sum_s = (rr_sum_s >= NCH) ? rr_sum_s - NCH : rr_sum_s;
                if (rot_wide_s[j]) begin
                    grant_s     = SELW'(rr_sum_s);
                    has_grant_s = 1'b1;
                end else begin
                    has_grant_s = has_grant_s;
                end
            end
        end
    end

    // Route the granted channel's data/valid and raise its ready.
    always_comb begin
        grant_data_s  = {WIDTH{1'b0}};
        grant_valid_s = 1'b0;
        in_ready      = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (has_grant_s && (grant_s == SELW'(k))) begin
                grant_data_s  = in_data[k*WIDTH +: WIDTH];
                grant_valid_s = in_valid[k];
                in_ready[k]   = load_en_s && !rst;
            end else begin
                in_ready[k]   = 1'b0;
            end
        end
    end

    // Output stage: load on transfer, bubble when loading without transfer, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (load_en_s) begin
            out_valid_r <= xfer_s;
            if (xfer_s) begin
                out_data_r <= grant_data_s;
                out_chan_r <= grant_s;
            end
        end
    end

    // Round-robin pointer moves past the channel just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {SELW{1'b0}};
        end else if ((MODE != 0) && xfer_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

`ifdef SEL_PIPE_MUX_CNT_EN
    logic [31:0] xfer_cnt_r;

    // Count output handshakes; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_r <= 32'd0;
        end else if (out_valid_r && out_ready) begin
            xfer_cnt_r <= xfer_cnt_r + 32'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Scoreboard bench for sel_pipe_mux: an external-select instance (3 channels) and a
// round-robin instance (4 channels), directed scenarios followed by random traffic.
module tb_sel_pipe_mux;

    logic         clk;
    logic         rst;

    logic [95:0]  a_in_data;
    logic [2:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_select, a_out_chan;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready;

    logic [127:0] b_in_data;
    logic [3:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_select, b_out_chan;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_out_ready;

`ifdef SEL_PIPE_MUX_CNT_EN
    logic [31:0]  a_cnt, b_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [33:0] qa[$];
    logic [33:0] qb[$];
    bit  a_full = 1'b0;
    bit  b_full = 1'b0;
    int  b_rr   = 0;

    sel_pipe_mux #(.WIDTH(32), .NCH(3), .SELW(2), .MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .select(a_select),
        .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
`ifdef SEL_PIPE_MUX_CNT_EN
        , .xfer_cnt(a_cnt)
`endif
    );

    sel_pipe_mux #(.WIDTH(32), .NCH(4), .SELW(2), .MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .select(b_select),
        .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
`ifdef SEL_PIPE_MUX_CNT_EN
        , .xfer_cnt(b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input int ch, input logic [31:0] v);
        a_in_data = '0;
        a_in_data[ch*32 +: 32] = v;
    endtask

    // Reference rule: which channel is granted, or -1 if none.
    function automatic int pred_grant(input int mode, input int nch, input int sel,
                                      input logic [3:0] valid, input int rr);
        if (mode == 0) return (sel < nch) ? sel : -1;
        for (int i = 0; i < nch; i++) begin
            if (valid[(rr + i) % nch]) return (rr + i) % nch;
        end
        return -1;
    endfunction

    // Predictor A: expected ready/valid this cycle, push accepted beat.
    always @(negedge clk) begin : pred_a
        int g;
        logic [3:0] exp_rdy;
        bit load;
        if (rst) begin
            qa.delete();
            a_full = 1'b0;
        end else begin
            g = pred_grant(0, 3, int'(a_select), {1'b0, a_in_valid}, 0);
            load = !a_full || a_out_ready;
            exp_rdy = 4'b0;
            if (g >= 0 && load) exp_rdy[g] = 1'b1;
            chk("a_in_ready", {61'd0, a_in_ready}, {60'd0, exp_rdy});
            chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, a_full});
            if (load) begin
                a_full = 1'b0;
                if (g >= 0 && a_in_valid[g]) begin
                    qa.push_back({2'(g), 32'(a_in_data >> (g * 32))});
                    a_full = 1'b1;
                end
            end
        end
    end

    // Predictor B: round-robin by first valid channel at or after the favoured one.
    always @(negedge clk) begin : pred_b
        int g;
        logic [3:0] exp_rdy;
        bit load;
        if (rst) begin
            qb.delete();
            b_full = 1'b0;
            b_rr = 0;
        end else begin
            g = pred_grant(1, 4, 0, b_in_valid, b_rr);
            load = !b_full || b_out_ready;
            exp_rdy = 4'b0;
            if (g >= 0 && load) exp_rdy[g] = 1'b1;
            chk("b_in_ready", {60'd0, b_in_ready}, {60'd0, exp_rdy});
            chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, b_full});
            if (load) begin
                b_full = 1'b0;
                if (g >= 0 && b_in_valid[g]) begin
                    qb.push_back({2'(g), 32'(b_in_data >> (g * 32))});
                    b_full = 1'b1;
                    b_rr = (g + 1) % 4;
                end
            end
        end
    end

    // Monitor A: compare presented beat with scoreboard head, pop on handshake.
    always @(negedge clk) begin : mon_a
        logic [33:0] e;
        if (!rst && a_out_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_beat", {63'd0, a_out_valid}, 64'd0);
            end else begin
                e = qa[0];
                chk("a_out_data", {32'd0, a_out_data}, {32'd0, e[31:0]});
                chk("a_out_chan", {62'd0, a_out_chan}, {62'd0, e[33:32]});
                if (a_out_ready) void'(qa.pop_front());
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin : mon_b
        logic [33:0] e;
        if (!rst && b_out_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", {63'd0, b_out_valid}, 64'd0);
            end else begin
                e = qb[0];
                chk("b_out_data", {32'd0, b_out_data}, {32'd0, e[31:0]});
                chk("b_out_chan", {62'd0, b_out_chan}, {62'd0, e[33:32]});
                if (b_out_ready) void'(qb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_in_valid = '0; a_select = '0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_select = '0; b_out_ready = 1'b0;
        #1;
        chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_data", {32'd0, a_out_data}, 64'd0);
        chk("rst_a_chan", {62'd0, a_out_chan}, 64'd0);
        chk("rst_a_ready", {61'd0, a_in_ready}, 64'd0);
        chk("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        step(); step();
        rst = 1'b0;

        // Streaming on channel 2
        a_select = 2'd2;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 3'b100;
            put_a(2, 32'h10 + 32'(i));
            #1;
            chk("stream_in_ready", {61'd0, a_in_ready}, 64'b100);
            step();
            chk("stream_out_data", {32'd0, a_out_data}, 64'(32'h10 + 32'(i)));
            chk("stream_out_valid", {63'd0, a_out_valid}, 64'd1);
        end
        a_in_valid = 3'b000;
        step();

        // Stall: frozen output, second beat taken when out_ready returns
        a_select = 2'd1;
        a_in_valid = 3'b010;
        put_a(1, 32'hDEADBEEF);
        step();
        chk("stall_first", {32'd0, a_out_data}, 64'hDEADBEEF);
        a_out_ready = 1'b0;
        put_a(1, 32'h0000_2222);
        repeat (2) begin
            step();
            chk("stall_data", {32'd0, a_out_data}, 64'hDEADBEEF);
            chk("stall_ready", {61'd0, a_in_ready}, 64'd0);
        end
        a_out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {61'd0, a_in_ready}, 64'b010);
        step();
        chk("stall_second_data", {32'd0, a_out_data}, 64'h2222);
        chk("stall_second_chan", {62'd0, a_out_chan}, 64'd1);

        // Reset during a stall
        put_a(1, 32'hDEADBEEF);
        step();
        a_out_ready = 1'b0;
        a_in_valid = 3'b000;
        repeat (3) begin
            step();
            chk("mid_data", {32'd0, a_out_data}, 64'hDEADBEEF);
            chk("mid_chan", {62'd0, a_out_chan}, 64'd1);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, a_out_valid}, 64'd0);
        chk("async_rst_data", {32'd0, a_out_data}, 64'd0);
        chk("async_rst_chan", {62'd0, a_out_chan}, 64'd0);
        chk("async_rst_ready", {61'd0, a_in_ready}, 64'd0);
        step();
        rst = 1'b0;

        // Out-of-range select
        a_select = 2'd3;
        a_in_valid = 3'b111;
        a_in_data = {32'hC2, 32'hC1, 32'hC0};
        a_out_ready = 1'b1;
        #1;
        chk("oor_ready", {61'd0, a_in_ready}, 64'd0);
        repeat (2) begin
            step();
            chk("oor_valid", {63'd0, a_out_valid}, 64'd0);
        end
        a_in_valid = 3'b000;

`ifdef SEL_PIPE_MUX_CNT_EN
        // Handshake counter: 5 handshakes around a 2-cycle stall, then wrap
        chk("cnt_start", {32'd0, a_cnt}, 64'd0);
        a_select = 2'd0;
        a_out_ready = 1'b0;
        a_in_valid = 3'b001;
        put_a(0, 32'h100);
        step(); step(); step();
        a_out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            put_a(0, 32'h100 + 32'(i));
            step();
        end
        a_in_valid = 3'b000;
        step();
        chk("cnt_five", {32'd0, a_cnt}, 64'd5);
        dut_a.xfer_cnt_r <= 32'hFFFF_FFFF;
        #1;
        a_in_valid = 3'b001;
        step();
        a_in_valid = 3'b000;
        step();
        chk("cnt_wrap", {32'd0, a_cnt}, 64'd0);
`endif

        // Round-robin fairness
        b_out_ready = 1'b1;
        b_in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        b_in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_all", {62'd0, b_out_chan}, 64'(i % 4));
        end
        b_in_valid = 4'b0010;
        step();
        chk("rr_ch1", {62'd0, b_out_chan}, 64'd1);
        b_in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_odd", {62'd0, b_out_chan}, (i % 2 == 0) ? 64'd3 : 64'd1);
        end
        b_in_valid = 4'b0000;
        step();

        // Random traffic on both instances
        repeat (400) begin
            a_in_valid  = 3'($urandom);
            a_select    = 2'($urandom_range(0, 3));
            a_in_data   = {$urandom, $urandom, $urandom};
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = 4'($urandom);
            b_select    = 2'($urandom);
            b_in_data   = {$urandom, $urandom, $urandom, $urandom};
            b_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        a_in_valid = '0; a_out_ready = 1'b1;
        b_in_valid = '0; b_out_ready = 1'b1;
        repeat (3) step();
        chk("a_drained", 64'(qa.size()), 64'd0);
        chk("b_drained", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
